address_order: RTL and testbench

- Generates bit-reversed memory addresses for FFT input samples arriving as butterfly pairs (a, b).
- Each time the upstream loader reports a new sample-load count, the block emits two addresses: the a-sample address, then the b-sample address.
- The addresses are the bit-reversal of a running 10-bit sample index, i.e. decimation-in-time input ordering for a 1024-point FFT.
- Sits between the sample loader and the sample RAM write port.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/address_order.sv | 82 ++++++++
 tb/tb_address_order.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants, address-generator state encoding and the bit-reversal
// helper used by both the input address generator and the output reorder.
package fft_pkg;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 10;
    localparam int CNT_W   = 3;
    localparam int MAX_CNT = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        B_ADDR = 1'b1
    } addr_state_t;

    // Output bit i takes input bit (ADDR_W-1-i).
    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] x);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = x[ADDR_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/address_order.sv
// Bit-reversed (decimation-in-time) RAM address generator for FFT input pairs:
// each new loader count emits the a-sample address, then the b-sample address.
module address_order
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic [DATA_W-1:0] a_real,
    input  logic [DATA_W-1:0] a_imag,
    input  logic [DATA_W-1:0] b_real,
    input  logic [DATA_W-1:0] b_imag,
    input  logic [CNT_W-1:0]  samples_loaded_count,
    output logic [ADDR_W-1:0] output_address
);

    localparam logic [CNT_W-1:0]  MAX_CNT_V = CNT_W'(MAX_CNT);
    localparam logic [ADDR_W-2:0] PAIR_ONE  = (ADDR_W-1)'(1);

    // Sample data rides alongside the addresses but does not steer them.
    logic unused_data;
    assign unused_data = ^{a_real, a_imag, b_real, b_imag};

    addr_state_t       state_q, state_d;
    logic [CNT_W-1:0]  prev_cnt_q, prev_cnt_d;
    logic [ADDR_W-2:0] pair_idx_q, pair_idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic cnt_legal;
    logic load_event;
    logic frame_restart;

    always_comb begin
        cnt_legal     = (samples_loaded_count <= MAX_CNT_V);
        load_event    = (samples_loaded_count != prev_cnt_q) &&
                        (samples_loaded_count != '0) && cnt_legal;
        frame_restart = (samples_loaded_count == '0) && (prev_cnt_q != '0);
    end

    always_comb begin
        state_d    = state_q;
        prev_cnt_d = prev_cnt_q;
        pair_idx_d = pair_idx_q;
        addr_d     = addr_q;
        case (state_q)
            IDLE: begin
                if (load_event) begin
                    addr_d     = bitrev({pair_idx_q, 1'b0});
                    prev_cnt_d = samples_loaded_count;
                    state_d    = B_ADDR;
                end else if (frame_restart) begin
                    prev_cnt_d = '0;
                    pair_idx_d = '0;
                end
            end
            B_ADDR: begin
                // prev_cnt is left alone here so a count change during this
                // cycle is still seen as an event on the following IDLE cycle.
                addr_d     = bitrev({pair_idx_q, 1'b1});
                pair_idx_d = pair_idx_q + PAIR_ONE;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q    <= IDLE;
            prev_cnt_q <= '0;
            pair_idx_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            prev_cnt_q <= prev_cnt_d;
            pair_idx_q <= pair_idx_d;
            addr_q     <= addr_d;
        end
    end

    assign output_address = addr_q;

endmodule

// File: tb/tb_address_order.sv
// Directed-vector bench for address_order: reset, pair sequence, mid-pair count
// changes, illegal counts, frame restart, mid-pair reset and pair-index wrap.
module tb_address_order;

    logic       clk = 1'b0;
    logic       nrst;
    logic [9:0] a_real, a_imag, b_real, b_imag;
    logic [2:0] samples_loaded_count;
    logic [9:0] output_address;

    int n_checks = 0;
    int n_errors = 0;

    address_order dut (
        .clk                  (clk),
        .nrst                 (nrst),
        .a_real               (a_real),
        .a_imag               (a_imag),
        .b_real               (b_real),
        .b_imag               (b_imag),
        .samples_loaded_count (samples_loaded_count),
        .output_address       (output_address)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: addr %0d", tag, got);
        end
    endtask

    // Advance one rising edge and settle just after it; inputs change here too.
    task automatic step();
        @(posedge clk);
        #1;
        a_real = 10'($urandom);
        a_imag = 10'($urandom);
        b_real = 10'($urandom);
        b_imag = 10'($urandom);
    endtask

    task automatic do_reset();
        nrst = 1'b1;
        samples_loaded_count = 3'd0;
        step();
        step();
        nrst = 1'b0;
    endtask

    // Reverse the low 9 bits of p: the a-address of pair p is this value,
    // the b-address adds the top bit (512).
    function automatic int rev9(input int p);
        int r;
        r = 0;
        for (int i = 0; i < 9; i++) r = (r << 1) | ((p >> i) & 1);
        return r;
    endfunction

    int exp_seq[8] = '{0, 512, 256, 768, 128, 640, 384, 896};

    initial begin
        nrst = 1'b1;
        samples_loaded_count = 3'd0;
        a_real = '0; a_imag = '0; b_real = '0; b_imag = '0;

        // Reset state and hold after release
        step();
        step();
        check_eq("reset", output_address, 0);
        nrst = 1'b0;
        step();
        step();
        check_eq("post_reset_idle", output_address, 0);

        // Count 1..4, each held for several cycles
        for (int c = 1; c <= 4; c++) begin
            samples_loaded_count = 3'(c);
            step();
            check_eq($sformatf("seq%0d_a", c), output_address, exp_seq[2*c-2]);
            step();
            check_eq($sformatf("seq%0d_b", c), output_address, exp_seq[2*c-1]);
            step();
            check_eq($sformatf("seq%0d_hold", c), output_address, exp_seq[2*c-1]);
        end

        // Count change while in B_ADDR must not be lost
        do_reset();
        samples_loaded_count = 3'd1;
        step();
        check_eq("mid_a0", output_address, 0);
        samples_loaded_count = 3'd2;
        step();
        check_eq("mid_b0", output_address, 512);
        step();
        check_eq("mid_a1", output_address, 256);
        step();
        check_eq("mid_b1", output_address, 768);
        step();
        check_eq("mid_hold", output_address, 768);

        // Illegal counts are ignored; pair index is unchanged afterwards
        samples_loaded_count = 3'd5;
        step();
        step();
        check_eq("illegal5", output_address, 768);
        samples_loaded_count = 3'd7;
        step();
        check_eq("illegal7", output_address, 768);
        samples_loaded_count = 3'd3;
        step();
        check_eq("resume_a2", output_address, 128);
        step();
        check_eq("resume_b2", output_address, 640);

        // Frame restart via count 0
        samples_loaded_count = 3'd0;
        step();
        check_eq("restart_hold", output_address, 640);
        step();
        samples_loaded_count = 3'd1;
        step();
        check_eq("restart_a0", output_address, 0);
        step();
        check_eq("restart_b0", output_address, 512);

        // Reset between a- and b-address cycles
        samples_loaded_count = 3'd2;
        step();
        check_eq("prerst_a1", output_address, 256);
        nrst = 1'b1;
        step();
        check_eq("midrst", output_address, 0);
        nrst = 1'b0;
        step();
        check_eq("postrst_a0", output_address, 0);
        step();
        check_eq("postrst_b0", output_address, 512);

        // 512 events alternating 1/2, then wrap back to pair 0
        do_reset();
        for (int p = 0; p < 512; p++) begin
            samples_loaded_count = (p % 2 == 0) ? 3'd1 : 3'd2;
            step();
            check_eq($sformatf("wrap_p%0d_a", p), output_address, rev9(p));
            step();
            check_eq($sformatf("wrap_p%0d_b", p), output_address, 512 + rev9(p));
        end
        samples_loaded_count = 3'd1;
        step();
        check_eq("wrapped_a0", output_address, 0);
        step();
        check_eq("wrapped_b0", output_address, 512);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
